// File: rtl/dp_ram_pkg.sv
// Shared types and parameter checks for the true dual-port RAM.
// Imported by the top level and the read pipeline.
package dp_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_e;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 2;

  function automatic bit read_lat_legal(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

  function automatic bit rw_mode_legal(input int mode);
    return (mode == RD_FIRST) || (mode == WR_FIRST);
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// READ_LAT-stage read-result shift register for one RAM port.
// Each stage only loads on a valid beat, so the last stage holds the previous result.
module dp_ram_rd_pipe
  import dp_ram_pkg::*;
#(
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o
);

  for (genvar s = 0; s < READ_LAT; s++) begin : g_stage
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              valid_q;
    logic [DATA_W-1:0] data_q;

    if (s == 0) begin : g_head
      assign src_valid = in_valid_i;
      assign src_data  = in_data_i;
    end else begin : g_body
      assign src_valid = g_stage[s-1].valid_q;
      assign src_data  = g_stage[s-1].data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= src_valid;
        if (src_valid) begin
          data_q <= src_data;
        end
      end
    end
  end

  assign out_valid_o = g_stage[READ_LAT-1].valid_q;
  assign out_data_o  = g_stage[READ_LAT-1].data_q;

endmodule

// File: rtl/dual_port_ram_tdp.sv
// True dual-port RAM: two independent read/write ports on one clock, port-A-wins
// write arbitration with a collision pulse, and an optional post-reset clear sweep.
module dual_port_ram_tdp
  import dp_ram_pkg::*;
#(
  parameter int DATA_W         = 4,
  parameter int ADDR_W         = 8,
  parameter int READ_LAT       = 1,
  parameter int RW_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              a_chip_selection,
  input  logic              a_write,
  input  logic              a_read,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_data_in,
  output logic [DATA_W-1:0] a_data_out,
  output logic              a_valid,

  input  logic              b_chip_selection,
  input  logic              b_write,
  input  logic              b_read,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_data_in,
  output logic [DATA_W-1:0] b_data_out,
  output logic              b_valid,

  output logic              busy,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam ram_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  if (!read_lat_legal(READ_LAT)) begin : g_bad_read_lat
    $error("dual_port_ram_tdp: READ_LAT must be 1 or 2");
  end
  if (!rw_mode_legal(RW_MODE)) begin : g_bad_rw_mode
    $error("dual_port_ram_tdp: RW_MODE must be 0 or 1");
  end

  ram_state_e        state_q, state_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic              clr_we;

  logic              a_we, a_rd, b_we, b_rd;
  logic              b_we_eff;
  logic [DATA_W-1:0] a_rd_word, b_rd_word;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              a_rd_valid_q, b_rd_valid_q;
  logic [DATA_W-1:0] a_rd_data_q, b_rd_data_q;
  logic              collision_q;

  // Clear FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear FSM: next state. The extra counter bit marks the final address written.
  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_d[ADDR_W]) begin
        state_d = ST_READY;
      end
    end
  end

  // Clear FSM: outputs.
  always_comb begin
    busy   = 1'b0;
    clr_we = 1'b0;
    if (state_q == ST_CLEAR) begin
      busy   = 1'b1;
      clr_we = 1'b1;
    end
  end

  assign a_we = a_chip_selection & a_write & ~busy;
  assign a_rd = a_chip_selection & a_read  & ~busy;
  assign b_we = b_chip_selection & b_write & ~busy;
  assign b_rd = b_chip_selection & b_read  & ~busy;

  // Port A wins a same-address write; port B's write is dropped.
  assign b_we_eff = b_we & ~(a_we && (a_address == b_address));

  assign a_rd_word = (RW_MODE == WR_FIRST && a_we) ? a_data_in : mem_q[a_address];
  assign b_rd_word = (RW_MODE == WR_FIRST && b_we) ? b_data_in : mem_q[b_address];

  // NOTE: the array and its read-data capture carry no reset branch; clearing
  // storage is the sweep's job, and a reset here would block RAM inference.
  // NOTE: non-blocking writes let a read on the same edge see the old word,
  // which is what yields read-first and cross-port old-data behaviour.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_cnt_q[ADDR_W-1:0]] <= '0;
    end else begin
      if (a_we) begin
        mem_q[a_address] <= a_data_in;
      end
      if (b_we_eff) begin
        mem_q[b_address] <= b_data_in;
      end
    end
    if (a_rd) begin
      a_rd_data_q <= a_rd_word;
    end
    if (b_rd) begin
      b_rd_data_q <= b_rd_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd_valid_q <= 1'b0;
      b_rd_valid_q <= 1'b0;
      collision_q  <= 1'b0;
    end else begin
      a_rd_valid_q <= a_rd;
      b_rd_valid_q <= b_rd;
      collision_q  <= a_we & b_we & (a_address == b_address);
    end
  end

  assign collision = collision_q;

  dp_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_rd_pipe_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (a_rd_valid_q),
    .in_data_i  (a_rd_data_q),
    .out_valid_o(a_valid),
    .out_data_o (a_data_out)
  );

  dp_ram_rd_pipe #(
    .DATA_W  (DATA_W),
    .READ_LAT(READ_LAT)
  ) u_rd_pipe_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (b_rd_valid_q),
    .in_data_i  (b_rd_data_q),
    .out_valid_o(b_valid),
    .out_data_o (b_data_out)
  );

endmodule

// File: tb/tb_dual_port_ram_tdp.sv
// Scoreboard bench: two RAM instances (READ_LAT 1 read-first, READ_LAT 2 write-first)
// share one stimulus stream; a reference memory predicts every read and collision.
module tb_dual_port_ram_tdp;

  localparam int DW    = 4;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_cs, a_wr, a_rd, b_cs, b_wr, b_rd;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;

  logic [DW-1:0] d0_a_dout, d0_b_dout, d1_a_dout, d1_b_dout;
  logic          d0_a_valid, d0_b_valid, d1_a_valid, d1_b_valid;
  logic          d0_busy, d1_busy, d0_col, d1_col;

  dual_port_ram_tdp u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_chip_selection(a_cs), .a_write(a_wr), .a_read(a_rd), .a_address(a_addr),
    .a_data_in(a_din), .a_data_out(d0_a_dout), .a_valid(d0_a_valid),
    .b_chip_selection(b_cs), .b_write(b_wr), .b_read(b_rd), .b_address(b_addr),
    .b_data_in(b_din), .b_data_out(d0_b_dout), .b_valid(d0_b_valid),
    .busy(d0_busy), .collision(d0_col)
  );

  dual_port_ram_tdp #(.READ_LAT(2), .RW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_chip_selection(a_cs), .a_write(a_wr), .a_read(a_rd), .a_address(a_addr),
    .a_data_in(a_din), .a_data_out(d1_a_dout), .a_valid(d1_a_valid),
    .b_chip_selection(b_cs), .b_write(b_wr), .b_read(b_rd), .b_address(b_addr),
    .b_data_in(b_din), .b_data_out(d1_b_dout), .b_valid(d1_b_valid),
    .busy(d1_busy), .collision(d1_col)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t q_a0[$], q_b0[$], q_a1[$], q_b1[$];
  int   q_c0[$], q_c1[$];
  logic [DW-1:0] model [DEPTH];
  exp_t mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
  endtask

  // Read-result and collision monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (d0_a_valid) begin
      if (q_a0.size() == 0) check("a0_spurious_valid", d0_a_valid, 1'b0);
      else begin
        mon_e = q_a0.pop_front();
        check("a0_data", d0_a_dout, mon_e.data);
        check("a0_latency", cyc, mon_e.cyc);
      end
    end else if (q_a0.size() != 0 && q_a0[0].cyc <= cyc) begin
      check("a0_valid", d0_a_valid, 1'b1);
      void'(q_a0.pop_front());
    end
    if (d0_b_valid) begin
      if (q_b0.size() == 0) check("b0_spurious_valid", d0_b_valid, 1'b0);
      else begin
        mon_e = q_b0.pop_front();
        check("b0_data", d0_b_dout, mon_e.data);
        check("b0_latency", cyc, mon_e.cyc);
      end
    end else if (q_b0.size() != 0 && q_b0[0].cyc <= cyc) begin
      check("b0_valid", d0_b_valid, 1'b1);
      void'(q_b0.pop_front());
    end
    if (d1_a_valid) begin
      if (q_a1.size() == 0) check("a1_spurious_valid", d1_a_valid, 1'b0);
      else begin
        mon_e = q_a1.pop_front();
        check("a1_data", d1_a_dout, mon_e.data);
        check("a1_latency", cyc, mon_e.cyc);
      end
    end else if (q_a1.size() != 0 && q_a1[0].cyc <= cyc) begin
      check("a1_valid", d1_a_valid, 1'b1);
      void'(q_a1.pop_front());
    end
    if (d1_b_valid) begin
      if (q_b1.size() == 0) check("b1_spurious_valid", d1_b_valid, 1'b0);
      else begin
        mon_e = q_b1.pop_front();
        check("b1_data", d1_b_dout, mon_e.data);
        check("b1_latency", cyc, mon_e.cyc);
      end
    end else if (q_b1.size() != 0 && q_b1[0].cyc <= cyc) begin
      check("b1_valid", d1_b_valid, 1'b1);
      void'(q_b1.pop_front());
    end
    if (d0_col) begin
      if (q_c0.size() == 0) check("col0_spurious", d0_col, 1'b0);
      else check("col0_cycle", cyc, q_c0.pop_front());
    end else if (q_c0.size() != 0 && q_c0[0] <= cyc) begin
      check("col0_pulse", d0_col, 1'b1);
      void'(q_c0.pop_front());
    end
    if (d1_col) begin
      if (q_c1.size() == 0) check("col1_spurious", d1_col, 1'b0);
      else check("col1_cycle", cyc, q_c1.pop_front());
    end else if (q_c1.size() != 0 && q_c1[0] <= cyc) begin
      check("col1_pulse", d1_col, 1'b1);
      void'(q_c1.pop_front());
    end
  end

  task automatic idle_in();
    a_cs = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_addr = '0; a_din = '0;
    b_cs = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_addr = '0; b_din = '0;
  endtask

  task automatic idle(input int n);
    idle_in();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One cycle of stimulus; predictions are pushed before the accepting edge.
  task automatic drive(input bit acs, input bit awr, input bit ard, input logic [AW-1:0] aad,
                       input logic [DW-1:0] adi, input bit bcs, input bit bwr, input bit brd,
                       input logic [AW-1:0] bad, input logic [DW-1:0] bdi);
    logic [DW-1:0] old_a, old_b;
    bit awe, are, bwe, bre;
    a_cs = acs; a_wr = awr; a_rd = ard; a_addr = aad; a_din = adi;
    b_cs = bcs; b_wr = bwr; b_rd = brd; b_addr = bad; b_din = bdi;
    awe = acs & awr; are = acs & ard;
    bwe = bcs & bwr; bre = bcs & brd;
    old_a = model[aad];
    old_b = model[bad];
    if (are) begin
      q_a0.push_back('{old_a, cyc + 2});
      q_a1.push_back('{(awe ? adi : old_a), cyc + 3});
    end
    if (bre) begin
      q_b0.push_back('{old_b, cyc + 2});
      q_b1.push_back('{(bwe ? bdi : old_b), cyc + 3});
    end
    if (awe && bwe && aad == bad) begin
      q_c0.push_back(cyc + 1);
      q_c1.push_back(cyc + 1);
    end
    if (bwe) model[bad] = bdi;
    if (awe) model[aad] = adi;
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [AW-1:0] aad, input logic [AW-1:0] bad);
    drive(1'b1, 1'b0, 1'b1, aad, '0, 1'b1, 1'b0, 1'b1, bad, '0);
  endtask

  task automatic flush_sb();
    q_a0.delete(); q_b0.delete(); q_a1.delete(); q_b1.delete();
    q_c0.delete(); q_c1.delete();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a0_dout"}, d0_a_dout, 0);
    check({tag, "_b0_dout"}, d0_b_dout, 0);
    check({tag, "_a1_dout"}, d1_a_dout, 0);
    check({tag, "_b1_dout"}, d1_b_dout, 0);
    check({tag, "_a0_valid"}, d0_a_valid, 0);
    check({tag, "_b0_valid"}, d0_b_valid, 0);
    check({tag, "_a1_valid"}, d1_a_valid, 0);
    check({tag, "_b1_valid"}, d1_b_valid, 0);
    check({tag, "_col0"}, d0_col, 0);
    check({tag, "_col1"}, d1_col, 0);
    check({tag, "_busy0"}, d0_busy, 1);
    check({tag, "_busy1"}, d1_busy, 1);
  endtask

  // Counts busy cycles after reset release; optionally pokes requests that must be dropped.
  task automatic sweep(input bit poke);
    int n0, n1, guard;
    n0 = 0; n1 = 0; guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (d0_busy) n0++;
      if (d1_busy) n1++;
      if (poke && guard == 200) begin
        a_cs = 1'b1; a_wr = 1'b1; a_addr = 8'h10; a_din = 4'hA;
        b_cs = 1'b1; b_rd = 1'b1; b_addr = 8'h10;
      end
      if (poke && guard == 201) idle_in();
    end while ((d0_busy || d1_busy) && guard < 400);
    idle_in();
    check("sweep_busy_cycles_d0", n0, 256);
    check("sweep_busy_cycles_d1", n1, 256);
  endtask

  initial begin
    idle_in();
    flush_sb();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    sweep(1'b1);

    // Cleared contents, ignored busy-time write, basic cross-port access.
    rd2(8'hFF, 8'h10);
    drive(1'b1, 1'b1, 1'b0, 8'h01, 4'h1, 1'b1, 1'b1, 1'b0, 8'h02, 4'h2);
    rd2(8'h02, 8'h01);
    idle(3);
    rd2(8'h01, 8'h02);
    rd2(8'h02, 8'h01);
    rd2(8'h10, 8'hFF);
    rd2(8'h01, 8'h01);

    // Same-address write collision: A wins.
    drive(1'b1, 1'b1, 1'b0, 8'h05, 4'h3, 1'b1, 1'b1, 1'b0, 8'h05, 4'hC);
    rd2(8'h05, 8'h05);

    // Read-during-write on 0x07: same-port per RW_MODE, cross-port always old.
    drive(1'b1, 1'b1, 1'b1, 8'h07, 4'h9, 1'b1, 1'b0, 1'b1, 8'h07, 4'h0);
    rd2(8'h07, 8'h07);
    idle(3);

    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'h20 + 8'($urandom_range(0, 3)), 4'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'h20 + 8'($urandom_range(0, 3)), 4'($urandom));
    end
    idle(4);

    // Reset with reads in flight: results are lost and outputs return to zero.
    rd2(8'h01, 8'h02);
    idle(3);
    rd2(8'h02, 8'h01);
    rst_n = 1'b0;
    flush_sb();
    #1;
    check_reset_outputs("inflight");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset mid-sweep: the sweep restarts and runs a full 256 cycles.
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midsweep");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sweep(1'b0);

    rd2(8'h01, 8'h02);
    rd2(8'h05, 8'h07);
    idle(5);

    check("a0_drained", q_a0.size(), 0);
    check("b0_drained", q_b0.size(), 0);
    check("a1_drained", q_a1.size(), 0);
    check("b1_drained", q_b1.size(), 0);
    check("col_drained", q_c0.size() + q_c1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
